// File: rtl/reg_file_scoreboard_if.sv
// Register-address bundle between decode/writeback and the register-file scoreboard.
// Latency: none, this is wiring only.
// Backpressure: stall_o flows back to decode, which holds its instruction while it is high.
interface reg_file_scoreboard_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] reg_addr_1_i;
  logic [ADDR_WIDTH-1:0] reg_addr_2_i;
  logic [ADDR_WIDTH-1:0] reg_dest_addr_i;
  logic                  src1_used_i;
  logic                  src2_used_i;
  logic                  issue_valid_i;
  logic                  issue_wr_en_i;
  logic                  wb_valid_i;
  logic [ADDR_WIDTH-1:0] wb_addr_i;
  logic [DATA_WIDTH-1:0] wb_data_i;
  logic                  flush_i;
  logic [DATA_WIDTH-1:0] reg_data_1_o;
  logic [DATA_WIDTH-1:0] reg_data_2_o;
  logic                  stall_o;
  logic                  err_o;

  // Decode/writeback side
  modport master (
    output reg_addr_1_i, reg_addr_2_i, reg_dest_addr_i, src1_used_i, src2_used_i,
    output issue_valid_i, issue_wr_en_i, wb_valid_i, wb_addr_i, wb_data_i, flush_i,
    input  reg_data_1_o, reg_data_2_o, stall_o, err_o
  );

  // Register-file scoreboard side
  modport slave (
    input  reg_addr_1_i, reg_addr_2_i, reg_dest_addr_i, src1_used_i, src2_used_i,
    input  issue_valid_i, issue_wr_en_i, wb_valid_i, wb_addr_i, wb_data_i, flush_i,
    output reg_data_1_o, reg_data_2_o, stall_o, err_o
  );
endinterface

// File: rtl/reg_file_scoreboard.sv
// Register file with per-register pending-write counters; stalls decode on RAW or full counter.
// Latency: read data and stall are combinational; writes and counter updates take effect on the next edge.
// Backpressure: stall_o holds decode; writeback is never blocked. Define REG_FILE_BYPASS_EN to forward writeback data.
module reg_file_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_REGS   = 16,  // must equal 2**ADDR_WIDTH
  parameter int PEND_WIDTH = 2
) (
  input logic                  clk_i,
  input logic                  rst_i,
  reg_file_scoreboard_if.slave bus
);

  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
  localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [PEND_WIDTH-1:0] pend_q [NUM_REGS];
  logic [PEND_WIDTH-1:0] pend_d [NUM_REGS];
  logic                  err_q;
  logic                  err_d;

  logic [PEND_WIDTH-1:0] pend_1;
  logic [PEND_WIDTH-1:0] pend_2;
  logic [PEND_WIDTH-1:0] pend_dst;
  logic                  rdy_1;
  logic                  rdy_2;
  logic [DATA_WIDTH-1:0] data_1;
  logic [DATA_WIDTH-1:0] data_2;
  logic                  stall;
  logic                  accept;
  logic [NUM_REGS-1:0]   inc_vec;
  logic [NUM_REGS-1:0]   dec_vec;

  assign pend_1   = pend_q[bus.reg_addr_1_i];
  assign pend_2   = pend_q[bus.reg_addr_2_i];
  assign pend_dst = pend_q[bus.reg_dest_addr_i];

`ifdef REG_FILE_BYPASS_EN
  logic wb_hit_1;
  logic wb_hit_2;

  assign wb_hit_1 = bus.wb_valid_i && (bus.wb_addr_i == bus.reg_addr_1_i);
  assign wb_hit_2 = bus.wb_valid_i && (bus.wb_addr_i == bus.reg_addr_2_i);

  // Forward same-cycle writeback; the last outstanding write landing now satisfies the source
  always_comb begin
    data_1 = wb_hit_1 ? bus.wb_data_i : regs_q[bus.reg_addr_1_i];
    data_2 = wb_hit_2 ? bus.wb_data_i : regs_q[bus.reg_addr_2_i];
    rdy_1  = (pend_1 == '0) || ((pend_1 == PEND_ONE) && wb_hit_1);
    rdy_2  = (pend_2 == '0) || ((pend_2 == PEND_ONE) && wb_hit_2);
  end
`else
  // No forwarding: a source waits until its writeback has reached the array
  always_comb begin
    data_1 = regs_q[bus.reg_addr_1_i];
    data_2 = regs_q[bus.reg_addr_2_i];
    rdy_1  = (pend_1 == '0);
    rdy_2  = (pend_2 == '0);
  end
`endif

  // Hold decode on an unready source or a destination whose counter would overflow
  always_comb begin
    stall = 1'b0;
    if (bus.issue_valid_i) begin
      stall = (bus.src1_used_i && !rdy_1) ||
              (bus.src2_used_i && !rdy_2) ||
              (bus.issue_wr_en_i && (pend_dst == PEND_MAX));
    end
    accept = bus.issue_valid_i && !stall && bus.issue_wr_en_i;
  end

  // Per-register increment (accepted issue) and decrement (writeback to a pending entry)
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_vec[r] = accept && (bus.reg_dest_addr_i == ADDR_WIDTH'(r));
      dec_vec[r] = bus.wb_valid_i && (bus.wb_addr_i == ADDR_WIDTH'(r)) && (pend_q[r] != '0);
    end
  end

  // Next counter values; flush wins over any increment or decrement
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = pend_q[r];
      if (bus.flush_i) begin
        pend_d[r] = '0;
      end else if (inc_vec[r] && !dec_vec[r]) begin
        pend_d[r] = pend_q[r] + PEND_ONE;
      end else if (dec_vec[r] && !inc_vec[r]) begin
        pend_d[r] = pend_q[r] - PEND_ONE;
      end
    end
    err_d = err_q || (bus.wb_valid_i && (pend_q[bus.wb_addr_i] == '0));
  end

  // Register array: writeback always lands, even during stall or flush
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
    end else if (bus.wb_valid_i) begin
      regs_q[bus.wb_addr_i] <= bus.wb_data_i;
    end
  end

  // Pending counters and sticky underflow flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) pend_q[r] <= pend_d[r];
      err_q <= err_d;
    end
  end

  assign bus.reg_data_1_o = data_1;
  assign bus.reg_data_2_o = data_2;
  assign bus.stall_o      = stall;
  assign bus.err_o        = err_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed table-driven bench for reg_file_scoreboard, with a mid-cycle reset sequence.
// Latency: one vector per clock; outputs sampled 1 ns after the falling edge.
// Backpressure: stall_o is compared, never obeyed; vectors encode the expected hold behaviour.
module tb_reg_file_scoreboard;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic        iv, we, s1, s2;
    logic [3:0]  a1, a2, dst;
    logic        wbv;
    logic [3:0]  wba;
    logic [31:0] wbd;
    logic        fl;
    logic        es;
    logic [31:0] ed1, ed2;
    logic        ee;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];
  int   split;

  reg_file_scoreboard_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) bus ();

  reg_file_scoreboard #(
    .DATA_WIDTH(32), .ADDR_WIDTH(4), .NUM_REGS(16), .PEND_WIDTH(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm, input logic iv, we, s1, s2,
                     input logic [3:0] a1, a2, dst, input logic wbv, input logic [3:0] wba,
                     input logic [31:0] wbd, input logic fl, input logic es,
                     input logic [31:0] ed1, ed2, input logic ee);
    vec_t v;
    v.nm = nm; v.iv = iv; v.we = we; v.s1 = s1; v.s2 = s2;
    v.a1 = a1; v.a2 = a2; v.dst = dst; v.wbv = wbv; v.wba = wba; v.wbd = wbd;
    v.fl = fl; v.es = es; v.ed1 = ed1; v.ed2 = ed2; v.ee = ee;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    bus.issue_valid_i   = v.iv;
    bus.issue_wr_en_i   = v.we;
    bus.src1_used_i     = v.s1;
    bus.src2_used_i     = v.s2;
    bus.reg_addr_1_i    = v.a1;
    bus.reg_addr_2_i    = v.a2;
    bus.reg_dest_addr_i = v.dst;
    bus.wb_valid_i      = v.wbv;
    bus.wb_addr_i       = v.wba;
    bus.wb_data_i       = v.wbd;
    bus.flush_i         = v.fl;
  endtask

  task automatic run_row(input vec_t v);
    @(negedge clk_i);
    drive(v);
    #1;
    check({v.nm, ".stall"}, 32'(bus.stall_o), 32'(v.es));
    check({v.nm, ".data1"}, bus.reg_data_1_o, v.ed1);
    check({v.nm, ".data2"}, bus.reg_data_2_o, v.ed2);
    check({v.nm, ".err"},   32'(bus.err_o),   32'(v.ee));
  endtask

  initial begin
    vec_t idle;
    // name               iv we s1 s2 a1 a2 dst wbv wba wbd           fl  stall         data1                        data2         err
    add("rst_src1_r3",     1, 0, 1, 0, 3, 0, 0,  0, 0, 0,             0,  0,            0,                           0,            0);
    add("issue_wr_r2",     1, 1, 0, 0, 0, 0, 2,  0, 0, 0,             0,  0,            0,                           0,            0);
    add("raw_r2_stall",    1, 0, 1, 0, 2, 0, 0,  0, 0, 0,             0,  1,            0,                           0,            0);
    add("raw_r2_wb",       1, 0, 1, 0, 2, 0, 0,  1, 2, 32'hDEADBEEF,  0,  !BYP,         BYP ? 32'hDEADBEEF : 32'h0,  0,            0);
    add("raw_r2_after",    1, 0, 1, 0, 2, 2, 0,  0, 0, 0,             0,  0,            32'hDEADBEEF,                32'hDEADBEEF, 0);
    add("wr_r5_a",         1, 1, 0, 0, 0, 0, 5,  0, 0, 0,             0,  0,            0,                           0,            0);
    add("wr_r5_b",         1, 1, 0, 0, 0, 0, 5,  0, 0, 0,             0,  0,            0,                           0,            0);
    add("wr_r5_c",         1, 1, 0, 0, 0, 0, 5,  0, 0, 0,             0,  0,            0,                           0,            0);
    add("r5_max_wb",       1, 1, 0, 0, 0, 0, 5,  1, 5, 32'h50,        0,  1,            0,                           0,            0);
    add("r5_proceed",      1, 1, 0, 0, 5, 0, 5,  0, 0, 0,             0,  0,            32'h50,                      0,            0);
    add("r5_max_again",    1, 1, 0, 0, 0, 0, 5,  0, 0, 0,             0,  1,            0,                           0,            0);
    add("wr_r7",           1, 1, 0, 0, 0, 0, 7,  0, 0, 0,             0,  0,            0,                           0,            0);
    add("r7_inc_dec",      1, 1, 0, 0, 0, 0, 7,  1, 7, 32'h77,        0,  0,            0,                           0,            0);
    add("r7_still_pend",   1, 0, 1, 0, 7, 0, 0,  0, 0, 0,             0,  1,            32'h77,                      0,            0);
    add("r7_wb",           1, 0, 1, 0, 7, 0, 0,  1, 7, 32'h88,        0,  !BYP,         BYP ? 32'h88 : 32'h77,       0,            0);
    add("r7_clear",        1, 0, 1, 0, 7, 0, 0,  0, 0, 0,             0,  0,            32'h88,                      0,            0);
    add("wb_r9_underflow", 0, 0, 0, 0, 0, 0, 0,  1, 9, 32'h1234,      0,  0,            0,                           0,            0);
    add("err_set",         0, 0, 0, 0, 9, 0, 0,  0, 0, 0,             0,  0,            32'h1234,                    0,            1);
    add("err_sticky",      1, 0, 1, 0, 9, 0, 0,  0, 0, 0,             0,  0,            32'h1234,                    0,            1);
    add("wr_r1_a",         1, 1, 0, 0, 0, 0, 1,  0, 0, 0,             0,  0,            0,                           0,            1);
    add("wr_r1_b",         1, 1, 0, 0, 0, 0, 1,  0, 0, 0,             0,  0,            0,                           0,            1);
    add("wr_r4",           1, 1, 0, 0, 0, 0, 4,  0, 0, 0,             0,  0,            0,                           0,            1);
    add("r1_pend",         1, 0, 1, 0, 1, 0, 0,  0, 0, 0,             0,  1,            0,                           0,            1);
    add("flush_wb_r4",     1, 1, 0, 0, 0, 0, 6,  1, 4, 32'h55,        1,  0,            0,                           0,            1);
    add("post_flush_r1",   1, 0, 1, 1, 1, 4, 0,  0, 0, 0,             0,  0,            0,                           32'h55,       1);
    add("flush_drop_r6",   1, 0, 1, 0, 6, 0, 0,  0, 0, 0,             0,  0,            0,                           0,            1);
    add("flush_clr_r5",    1, 0, 1, 1, 5, 4, 0,  0, 0, 0,             0,  0,            32'h50,                      32'h55,       1);
    add("wr_r10",          1, 1, 0, 0, 0, 0, 10, 0, 0, 0,             0,  0,            0,                           0,            1);
    split = tbl.size();
    add("post_rst_wr_r3",  1, 1, 0, 0, 0, 0, 3,  0, 0, 0,             0,  0,            0,                           0,            0);
    add("post_rst_raw_r3", 1, 0, 1, 0, 3, 9, 0,  0, 0, 0,             0,  1,            0,                           0,            0);
    add("post_rst_wb_r3",  1, 0, 1, 0, 3, 0, 0,  1, 3, 32'hAB,        0,  !BYP,         BYP ? 32'hAB : 32'h0,        0,            0);
    add("post_rst_r3_ok",  1, 0, 1, 0, 3, 0, 0,  0, 0, 0,             0,  0,            32'hAB,                      0,            0);

    idle = tbl[0];
    idle.iv = 0; idle.we = 0; idle.s1 = 0; idle.s2 = 0; idle.a1 = 0; idle.a2 = 0;
    idle.dst = 0; idle.wbv = 0; idle.wba = 0; idle.wbd = 0; idle.fl = 0;
    drive(idle);
    #12 rst_i = 1'b0;

    for (int i = 0; i < split; i++) run_row(tbl[i]);

    // Mid-cycle asynchronous reset: r10 pending, r4 holds 0x55, err set
    @(negedge clk_i);
    idle.iv = 1; idle.s1 = 1; idle.a1 = 4'd10; idle.a2 = 4'd4;
    drive(idle);
    #1;
    check("pre_rst.stall", 32'(bus.stall_o), 32'd1);
    check("pre_rst.data2", bus.reg_data_2_o, 32'h55);
    check("pre_rst.err",   32'(bus.err_o),   32'd1);
    rst_i = 1'b1;
    #1;
    check("in_rst.stall", 32'(bus.stall_o), 32'd0);
    check("in_rst.data2", bus.reg_data_2_o, 32'h0);
    check("in_rst.err",   32'(bus.err_o),   32'd0);
    rst_i = 1'b0;
    #1;
    check("after_rst.stall", 32'(bus.stall_o), 32'd0);

    for (int i = split; i < tbl.size(); i++) run_row(tbl[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
